// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory signals of the system memory port.
// The arbiter takes the master side; CPU, chroni and memory the slave side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_ready;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rd_data;
  logic              vid_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic [1:0]        bus_owner;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wr_data,
    input  vid_req, vid_addr, mem_rd_data,
    output cpu_rd_data, cpu_ready,
    output vid_rd_data, vid_ready,
    output mem_addr, mem_wr_data, mem_wr_en,
    output bus_owner
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wr_data,
    output vid_req, vid_addr, mem_rd_data,
    input  cpu_rd_data, cpu_ready,
    input  vid_rd_data, vid_ready,
    input  mem_addr, mem_wr_data, mem_wr_en,
    input  bus_owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter between cornet_cpu and the chroni video fetch.
// One access at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int MEM_LATENCY   = 1,
  parameter int VIDEO_MAX_RUN = 4
) (
  input  logic sys_clk,
  input  logic reset,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] RUN_MAX  = 4'(VIDEO_MAX_RUN);
  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

  state_t     state;
  logic [1:0] lat_cnt;
  logic [3:0] vid_run;
  logic       owner_cpu;
  logic       is_wr;
  logic       grant_vid;
  logic       grant_cpu;

  // Video wins contention until it has taken RUN_MAX grants in a row.
  assign grant_vid = bus.vid_req &
                     (!bus.cpu_req | (vid_run < RUN_MAX));
  assign grant_cpu = bus.cpu_req & !grant_vid;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state           <= S_IDLE;
      lat_cnt         <= '0;
      vid_run         <= '0;
      owner_cpu       <= 1'b0;
      is_wr           <= 1'b0;
      bus.cpu_rd_data <= '0;
      bus.cpu_ready   <= 1'b0;
      bus.vid_rd_data <= '0;
      bus.vid_ready   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.bus_owner   <= 2'b00;
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.vid_ready <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_cpu) begin
            state         <= S_ISSUE;
            owner_cpu     <= 1'b1;
            is_wr         <= bus.cpu_we;
            vid_run       <= '0;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wr_en <= bus.cpu_we;
            bus.bus_owner <= 2'b01;
            if (bus.cpu_we)
              bus.mem_wr_data <= bus.cpu_wr_data;
          end else if (grant_vid) begin
            state         <= S_ISSUE;
            owner_cpu     <= 1'b0;
            is_wr         <= 1'b0;
            bus.mem_addr  <= bus.vid_addr;
            bus.bus_owner <= 2'b10;
            vid_run <= bus.cpu_req ?
                       4'(vid_run + 4'd1) : 4'd0;
          end
        end
        S_ISSUE: begin
          if (is_wr) begin
            state         <= S_DONE;
            bus.cpu_ready <= 1'b1;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_LAST;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= S_DONE;
            if (owner_cpu) begin
              bus.cpu_rd_data <= bus.mem_rd_data;
              bus.cpu_ready   <= 1'b1;
            end else begin
              bus.vid_rd_data <= bus.mem_rd_data;
              bus.vid_ready   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          bus.bus_owner <= 2'b00;
        end
      endcase
    end
  end

endmodule
